// File: rtl/game_flow_ctrl.sv
// Game-state sequencer: title, roam, fade-in, battle, fade-out and end screens (BATTLE_RETRY_EN: a loss returns to ROAM).
// Latency: outputs follow the state register one Clk after the triggering input; no backpressure, inputs outside their state are ignored.
module game_flow_ctrl #(
    parameter int          NUM_BATTLES  = 5,
    parameter int          TRANS_FRAMES = 8,
    parameter logic [7:0]  ENTER_KEY    = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       start_battle,
    input  logic       battle_done,
    input  logic       battle_won,
    output logic [2:0] state,
    output logic       is_title,
    output logic       is_roam,
    output logic       is_battle,
    output logic       battle_load,
    output logic [2:0] cur_battle,
    output logic [3:0] fade_level,
    output logic       game_won,
    output logic       game_lost
);

    localparam logic [3:0] FADE_MAX    = 4'(TRANS_FRAMES);
    localparam logic [2:0] LAST_BATTLE = 3'(NUM_BATTLES - 1);

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_ROAM      = 3'd1,
        S_TRANS_IN  = 3'd2,
        S_BATTLE    = 3'd3,
        S_TRANS_OUT = 3'd4,
        S_END_WIN   = 3'd5,
        S_END_LOSE  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic       frame_clk_q;
    logic [7:0] key_q;
    logic [3:0] fade_q, fade_d, fade_inc, fade_dec;
    logic [2:0] cur_q, cur_d;
    logic       won_q, won_d;
    logic       load_q, load_d;
    logic       frame_rise, enter_press;

    assign frame_rise  = frame_clk & ~frame_clk_q;
    assign enter_press = (keycode == ENTER_KEY) && (key_q != ENTER_KEY);
    assign fade_inc    = fade_q + 4'd1;
    assign fade_dec    = fade_q - 4'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_TITLE;
            frame_clk_q <= 1'b0;
            key_q       <= 8'd0;
            fade_q      <= 4'd0;
            cur_q       <= 3'd0;
            won_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_clk_q <= frame_clk;
            key_q       <= keycode;
            fade_q      <= fade_d;
            cur_q       <= cur_d;
            won_q       <= won_d;
            load_q      <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fade_d  = fade_q;
        cur_d   = cur_q;
        won_d   = won_q;
        load_d  = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (enter_press) begin
                    state_d = S_ROAM;
                    cur_d   = 3'd0;
                end
            end
            S_ROAM: begin
                if (start_battle) begin
                    state_d = S_TRANS_IN;
                    fade_d  = 4'd0;
                end
            end
            S_TRANS_IN: begin
                if (frame_rise) begin
                    fade_d = fade_inc;
                    if (fade_inc == FADE_MAX) begin
                        state_d = S_BATTLE;
                        load_d  = 1'b1;
                    end
                end
            end
            S_BATTLE: begin
                fade_d = FADE_MAX;
                if (battle_done) begin
                    won_d   = battle_won;
                    state_d = S_TRANS_OUT;
                end
            end
            S_TRANS_OUT: begin
                if (frame_rise) begin
                    fade_d = fade_dec;
                    if (fade_q == 4'd1) begin
                        // Last elite beaten ends the run; cur_battle never advances past it
                        if (won_q && cur_q == LAST_BATTLE) begin
                            state_d = S_END_WIN;
                        end else if (won_q) begin
                            state_d = S_ROAM;
                            cur_d   = cur_q + 3'd1;
                        end else begin
`ifdef BATTLE_RETRY_EN
                            state_d = S_ROAM;
`else
                            state_d = S_END_LOSE;
`endif
                        end
                    end
                end
            end
            S_END_WIN, S_END_LOSE: begin
                if (enter_press) begin
                    state_d = S_TITLE;
                    cur_d   = 3'd0;
                end
            end
            default: begin
                state_d = S_TITLE;
                fade_d  = 4'd0;
                cur_d   = 3'd0;
                won_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        is_title   = 1'b0;
        is_roam    = 1'b0;
        is_battle  = 1'b0;
        game_won   = 1'b0;
        game_lost  = 1'b0;
        fade_level = 4'd0;
        case (state_q)
            S_TITLE:     is_title   = 1'b1;
            S_ROAM:      is_roam    = 1'b1;
            S_TRANS_IN:  fade_level = fade_q;
            S_BATTLE: begin
                is_battle  = 1'b1;
                fade_level = FADE_MAX;
            end
            S_TRANS_OUT: fade_level = fade_q;
            S_END_WIN:   game_won   = 1'b1;
            S_END_LOSE:  game_lost  = 1'b1;
            default:     is_title   = 1'b0;
        endcase
    end

    assign state       = state_q;
    assign battle_load = load_q;
    assign cur_battle  = cur_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: full win run, loss, ignored inputs and mid-transition reset.
module tb_game_flow_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       start_battle = 1'b0;
    logic       battle_done = 1'b0;
    logic       battle_won = 1'b0;
    logic [2:0] state;
    logic       is_title, is_roam, is_battle, battle_load;
    logic [2:0] cur_battle;
    logic [3:0] fade_level;
    logic       game_won, game_lost;

    int n_cmp = 0;
    int n_err = 0;

    game_flow_ctrl #(.NUM_BATTLES(5), .TRANS_FRAMES(8), .ENTER_KEY(8'h28)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .start_battle(start_battle), .battle_done(battle_done), .battle_won(battle_won),
        .state(state), .is_title(is_title), .is_roam(is_roam), .is_battle(is_battle),
        .battle_load(battle_load), .cur_battle(cur_battle), .fade_level(fade_level),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic press_enter;
        keycode = 8'h28;
        tick;
        keycode = 8'd0;
        tick;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick;
        tick;
        Reset = 1'b0;
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++;
        if (is_title !== 1'b1) begin n_err++; $display("FAIL reset_is_title: got %0b want 1", is_title); end
        n_cmp++;
        if ({is_roam, is_battle, battle_load, game_won, game_lost} !== 5'b0)
            begin n_err++; $display("FAIL reset_flags: got %b want 00000", {is_roam, is_battle, battle_load, game_won, game_lost}); end
        n_cmp++;
        if ({cur_battle, fade_level} !== 7'd0)
            begin n_err++; $display("FAIL reset_cur_fade: got cur=%0d fade=%0d want 0/0", cur_battle, fade_level); end
    endtask

    task automatic test_title_ignores;
        start_battle = 1'b1; tick; start_battle = 1'b0; tick;
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL title_start_battle: got %0d want 0", state); end
        battle_done = 1'b1; battle_won = 1'b1; tick; battle_done = 1'b0; battle_won = 1'b0; tick;
        frame_clk = 1'b1; tick; frame_clk = 1'b0; tick;
        n_cmp++;
        if ({state, fade_level} !== {3'd0, 4'd0})
            begin n_err++; $display("FAIL title_done_frame: got state=%0d fade=%0d want 0/0", state, fade_level); end
    endtask

    task automatic test_enter_hold;
        keycode = 8'h28;
        for (int i = 0; i < 10; i++) begin
            tick;
            n_cmp++;
            if ({state, is_roam, cur_battle} !== {3'd1, 1'b1, 3'd0})
                begin n_err++; $display("FAIL enter_hold[%0d]: got state=%0d roam=%0b cur=%0d want 1/1/0", i, state, is_roam, cur_battle); end
        end
        keycode = 8'd0;
        tick;
    endtask

    task automatic test_roam_ignores;
        press_enter;
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL roam_enter: got %0d want 1", state); end
        battle_done = 1'b1; battle_won = 1'b0; tick; battle_done = 1'b0; tick;
        n_cmp++;
        if (state !== 3'd1) begin n_err++; $display("FAIL roam_battle_done: got %0d want 1", state); end
    endtask

    task automatic test_trans_in;
        int loads;
        loads = 0;
        start_battle = 1'b1; tick; start_battle = 1'b0;
        n_cmp++;
        if ({state, fade_level, is_roam} !== {3'd2, 4'd0, 1'b0})
            begin n_err++; $display("FAIL trans_in_entry: got state=%0d fade=%0d roam=%0b want 2/0/0", state, fade_level, is_roam); end
        for (int i = 0; i < 8; i++) begin
            frame_clk = 1'b1; tick; frame_clk = 1'b0;
            if (battle_load) loads++;
            n_cmp++;
            if (fade_level !== 4'(i + 1))
                begin n_err++; $display("FAIL trans_in_fade[%0d]: got %0d want %0d", i, fade_level, i + 1); end
            n_cmp++;
            if (state !== ((i == 7) ? 3'd3 : 3'd2))
                begin n_err++; $display("FAIL trans_in_state[%0d]: got %0d want %0d", i, state, (i == 7) ? 3 : 2); end
            tick;
            if (battle_load) loads++;
            if (is_roam) loads += 100;
        end
        tick;
        if (battle_load) loads++;
        n_cmp++;
        if (loads !== 1) begin n_err++; $display("FAIL battle_load_pulses: got %0d want 1 (roam leaks add 100)", loads); end
        n_cmp++;
        if ({is_battle, fade_level} !== {1'b1, 4'd8})
            begin n_err++; $display("FAIL battle_outputs: got battle=%0b fade=%0d want 1/8", is_battle, fade_level); end
    endtask

    task automatic test_trans_out(input logic win, input logic [2:0] exp_state, input logic [2:0] exp_cur);
        logic [2:0] cur_before;
        cur_before = cur_battle;
        battle_won = win; battle_done = 1'b1; tick; battle_done = 1'b0; battle_won = 1'b0;
        n_cmp++;
        if ({state, fade_level, is_battle} !== {3'd4, 4'd8, 1'b0})
            begin n_err++; $display("FAIL trans_out_entry: got state=%0d fade=%0d battle=%0b want 4/8/0", state, fade_level, is_battle); end
        for (int i = 0; i < 8; i++) begin
            frame_clk = 1'b1; tick; frame_clk = 1'b0;
            if (i < 7) begin
                n_cmp++;
                if ({state, fade_level, cur_battle} !== {3'd4, 4'(7 - i), cur_before})
                    begin n_err++; $display("FAIL trans_out_step[%0d]: got state=%0d fade=%0d cur=%0d want 4/%0d/%0d", i, state, fade_level, cur_battle, 7 - i, cur_before); end
            end
            tick;
        end
        n_cmp++;
        if ({state, cur_battle, fade_level} !== {exp_state, exp_cur, 4'd0})
            begin n_err++; $display("FAIL trans_out_end: got state=%0d cur=%0d fade=%0d want %0d/%0d/0", state, cur_battle, fade_level, exp_state, exp_cur); end
        n_cmp++;
        if ({is_roam, game_won, game_lost} !== {exp_state == 3'd1, exp_state == 3'd5, exp_state == 3'd6})
            begin n_err++; $display("FAIL trans_out_flags: got roam/won/lost=%b for state %0d", {is_roam, game_won, game_lost}, exp_state); end
    endtask

    task automatic test_win_run;
        for (int b = 0; b < 4; b++) begin
            test_trans_in;
            test_trans_out(1'b1, 3'd1, 3'(b + 1));
        end
        test_trans_in;
        test_trans_out(1'b1, 3'd5, 3'd4);
    endtask

    task automatic test_end_exit;
        keycode = 8'h28; tick;
        n_cmp++;
        if ({state, cur_battle, is_title, game_won} !== {3'd0, 3'd0, 1'b1, 1'b0})
            begin n_err++; $display("FAIL end_exit: got state=%0d cur=%0d title=%0b won=%0b want 0/0/1/0", state, cur_battle, is_title, game_won); end
        tick; tick;
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL held_key_retrigger: got %0d want 0", state); end
        keycode = 8'd0; tick;
    endtask

    task automatic test_loss;
        press_enter;
        test_trans_in; test_trans_out(1'b1, 3'd1, 3'd1);
        test_trans_in; test_trans_out(1'b1, 3'd1, 3'd2);
        test_trans_in;
`ifdef BATTLE_RETRY_EN
        test_trans_out(1'b0, 3'd1, 3'd2);
`else
        test_trans_out(1'b0, 3'd6, 3'd2);
        press_enter;
        n_cmp++;
        if ({state, cur_battle} !== {3'd0, 3'd0})
            begin n_err++; $display("FAIL lose_exit: got state=%0d cur=%0d want 0/0", state, cur_battle); end
`endif
    endtask

    task automatic test_reset_mid_trans;
        test_reset;
        press_enter;
        test_trans_in; test_trans_out(1'b1, 3'd1, 3'd1);
        start_battle = 1'b1; tick; start_battle = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame_clk = 1'b1; tick; frame_clk = 1'b0; tick;
        end
        n_cmp++;
        if ({state, fade_level, cur_battle} !== {3'd2, 4'd5, 3'd1})
            begin n_err++; $display("FAIL pre_reset: got state=%0d fade=%0d cur=%0d want 2/5/1", state, fade_level, cur_battle); end
        Reset = 1'b1; tick; Reset = 1'b0;
        n_cmp++;
        if ({state, fade_level, cur_battle, is_title} !== {3'd0, 4'd0, 3'd0, 1'b1})
            begin n_err++; $display("FAIL mid_reset: got state=%0d fade=%0d cur=%0d title=%0b want 0/0/0/1", state, fade_level, cur_battle, is_title); end
    endtask

    initial begin
        test_reset;
        test_title_ignores;
        test_enter_hold;
        test_roam_ignores;
        test_win_run;
        test_end_exit;
        test_loss;
        test_reset_mid_trans;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
